// File: rtl/rocketcpu_bus_scheduler.sv
// rtl/rocketcpu_bus_scheduler.sv - registered round-robin Wishbone scheduler for ibus, dbus and DMA
// Owns the shared slave bus for one cycle at a time and force-terminates hung cycles.
module rocketcpu_bus_scheduler #(
  parameter int          TIMEOUT_W   = 8,
  parameter logic [31:0] TIMEOUT_RDT = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic [31:0] i_dma_adr,
  input  logic [31:0] i_dma_dat,
  input  logic [3:0]  i_dma_sel,
  input  logic        i_dma_we,
  input  logic        i_dma_cyc,
  output logic [31:0] o_dma_rdt,
  output logic        o_dma_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = {TIMEOUT_W{1'b1}};

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic [2:0]  req;
  logic [1:0]  pick;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc;
  logic        busy, gcyc, fire_ack, fire_to, end_ack;

  assign req = {i_dma_cyc, i_dbus_cyc, i_ibus_cyc};

  // Search starts at the master after the last one served.
  always_comb begin
    pick = 2'd0;
    case (last_q)
      2'd1: begin
        if (req[1]) pick = 2'd2;
        else if (req[2]) pick = 2'd3;
        else if (req[0]) pick = 2'd1;
      end
      2'd2: begin
        if (req[2]) pick = 2'd3;
        else if (req[0]) pick = 2'd1;
        else if (req[1]) pick = 2'd2;
      end
      default: begin
        if (req[0]) pick = 2'd1;
        else if (req[1]) pick = 2'd2;
        else if (req[2]) pick = 2'd3;
      end
    endcase
  end

  always_comb begin
    m_adr = 32'h0;
    m_dat = 32'h0;
    m_sel = 4'h0;
    m_we  = 1'b0;
    m_cyc = 1'b0;
    case (grant_q)
      2'd1: begin
        m_adr = i_ibus_adr;
        m_sel = 4'hF;
        m_cyc = i_ibus_cyc;
      end
      2'd2: begin
        m_adr = i_dbus_adr;
        m_dat = i_dbus_dat;
        m_sel = i_dbus_sel;
        m_we  = i_dbus_we;
        m_cyc = i_dbus_cyc;
      end
      2'd3: begin
        m_adr = i_dma_adr;
        m_dat = i_dma_dat;
        m_sel = i_dma_sel;
        m_we  = i_dma_we;
        m_cyc = i_dma_cyc;
      end
      default: ;
    endcase
  end

  // A real ack always beats the watchdog; a dropped cyc suppresses both.
  assign busy     = (state_q == S_BUSY);
  assign gcyc     = busy & m_cyc;
  assign fire_ack = gcyc & i_wb_ack;
  assign fire_to  = gcyc & ~i_wb_ack & (wdog_q == WDOG_MAX);
  assign end_ack  = fire_ack | fire_to;

  assign o_wb_adr   = m_adr;
  assign o_wb_dat   = m_dat;
  assign o_wb_sel   = m_sel;
  assign o_wb_we    = m_we;
  assign o_wb_cyc   = gcyc & ~fire_to;
  assign o_grant    = grant_q;
  assign o_timeout  = fire_to;
  assign o_ibus_ack = end_ack & (grant_q == 2'd1);
  assign o_dbus_ack = end_ack & (grant_q == 2'd2);
  assign o_dma_ack  = end_ack & (grant_q == 2'd3);
  assign o_ibus_rdt = fire_to ? TIMEOUT_RDT : i_wb_rdt;
  assign o_dbus_rdt = fire_to ? TIMEOUT_RDT : i_wb_rdt;
  assign o_dma_rdt  = fire_to ? TIMEOUT_RDT : i_wb_rdt;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (pick != 2'd0) begin
          state_d = S_BUSY;
          grant_d = pick;
          wdog_d  = '0;
        end
      end
      S_BUSY: begin
        if (!m_cyc || end_ack) begin
          state_d = S_IDLE;
          grant_d = 2'd0;
          last_d  = grant_q;
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule
